fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage, immediately upstream of decode. Holds the fetch PC,
//  issues single-outstanding requests to instruction memory (valid/ready),
//  drives the IF/ID pipeline register (pc_decode, instr_decode) into decode,
//  and applies decode-resolved redirects (branch/JAL/JALR) by killing wrong-path fetches.
// PARAMETERS
//  XLEN      32            datapath/PC width
//  RESET_PC  32'h0000_0000 first fetch address after reset
// PORTS
//  clk            in   1     clock, all state on posedge
//  rst_n          in   1     asynchronous, active-low reset
//  imem_req_valid out  1     fetch request valid
//  imem_req_ready in   1     imem accepts request this cycle
//  imem_addr      out  XLEN  request address (word aligned)
//  imem_rsp_valid in   1     response data valid (>=1 cycle after accept)
//  imem_rsp_data  in   32    fetched instruction
//  stall_decode   in   1     hazard unit: hold IF/ID register
//  pc_sel         in   2     from control: 0 SEQ, 1 BR, 2 JAL, 3 JALR
//  br_true        in   1     branch condition from decode
//  br_decode      in   XLEN  branch target
//  jal_decode     in   XLEN  JAL target
//  jalr_decode    in   XLEN  JALR target
//  pc_decode      out  XLEN  IF/ID: PC of instr_decode
//  instr_decode   out  32    IF/ID: instruction (NOP when invalid)
//  valid_decode   out  1     IF/ID: instr_decode is a real instruction
// BEHAVIOUR
//  Reset (async): state=S_REQ, fetch_pc=RESET_PC, kill=0, pc_decode=0,
//   instr_decode=NOP (32'h0000_0013), valid_decode=0, imem_req_valid=0 in reset.
//  redirect = valid_decode & ~stall_decode & (pc_sel==JAL | pc_sel==JALR |
//   (pc_sel==BR & br_true)); target = selected addr with [1:0] forced to 0.
//  FSM:
//   S_REQ : imem_req_valid=1, imem_addr=fetch_pc. On ready: req_pc<=fetch_pc,
//           fetch_pc<=fetch_pc+4 (mod 2^XLEN), ->S_WAIT. rsp_valid ignored here.
//   S_WAIT: on rsp_valid: if kill -> drop, kill<=0, ->S_REQ; elif ~stall_decode
//           -> IF/ID <= {req_pc, rsp_data, 1}, ->S_REQ; else skid <= {req_pc,
//           rsp_data}, ->S_HOLD.
//   S_HOLD: when ~stall_decode -> IF/ID <= {skid, 1}, ->S_REQ.
//  IF/ID when ~stall_decode and no instruction delivered: bubble (NOP, valid=0).
//  IF/ID when stall_decode: all three outputs hold.
//  Redirect (highest priority, same cycle): fetch_pc<=target; IF/ID<=bubble;
//   S_WAIT or S_REQ-with-handshake -> kill<=1 (pending/accepted response dropped);
//   S_HOLD -> skid discarded, ->S_REQ. Redirect and rsp_valid together in
//   S_WAIT: response dropped, no kill left set. Never two outstanding requests.
//  Latency: request accept to IF/ID valid = rsp latency + 1 cycle; redirect to
//   target request = 1 cycle (S_WAIT: after killed response returns).
//  Reset mid-operation clears kill and skid; imem shares rst_n, so no stale
//   response is expected; any that arrives in S_REQ is ignored.
// STRUCTURE
//  constants.vh: `PC_SEL_SEQ/BR/JAL/JALR, `INSTR_NOP, fetch state encodings.
//  Sub-module pc_next_sel: combinational redirect/target mux (pc_sel, br_true,
//   targets -> redirect, target). FSM, skid and IF/ID register in fetch_stage.
// TESTING
//  1 Reset, ready=1, 1-cycle rsp: IF/ID gets pc 0,4,8 with valid=1, one
//    instruction every 2 cycles; imem_addr 0,4,8.
//  2 stall_decode=1 for 3 cycles as rsp for pc 8 arrives: S_HOLD, IF/ID holds
//    pc 4; after release IF/ID=pc 8, no lost/duplicated instruction.
//  3 JAL at pc 4 (jal_decode=0x100) while pc 8 in S_WAIT: pc 8 rsp dropped,
//    next imem_addr=0x100, next valid IF/ID pc=0x100.
//  4 BR with br_true=0 -> no redirect, sequential; br_true=1, br_decode=0x42
//    -> imem_addr 0x40 ([1:0] cleared).
//  5 Redirect coincident with rsp_valid in S_WAIT: rsp dropped, kill=0,
//    target requested next cycle.
//  6 rst_n low mid-S_WAIT: outputs go to reset values asynchronously; after
//    release first imem_addr=RESET_PC; fetch_pc 0xFFFF_FFFC wraps to 0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the instruction-fetch stage: pc_sel codes, the NOP
// bubble encoding, fetch FSM state encodings and the redirect-decision helper.
package fetch_stage_pkg;

  typedef logic [1:0] pc_sel_t;

  localparam pc_sel_t PC_SEL_SEQ  = 2'd0;
  localparam pc_sel_t PC_SEL_BR   = 2'd1;
  localparam pc_sel_t PC_SEL_JAL  = 2'd2;
  localparam pc_sel_t PC_SEL_JALR = 2'd3;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // Control-flow change requested by decode, ignoring validity and stalls.
  function automatic logic takes_redirect(input pc_sel_t sel, input logic br_true);
    logic taken;
    case (sel)
      PC_SEL_JAL:  taken = 1'b1;
      PC_SEL_JALR: taken = 1'b1;
      PC_SEL_BR:   taken = br_true;
      default:     taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Redirect target mux: picks the decode-resolved target for the current pc_sel
// and forces word alignment.
module fetch_stage_pc_next_sel
  import fetch_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [1:0]      pc_sel,
  input  logic            br_true,
  input  logic [XLEN-1:0] br_decode,
  input  logic [XLEN-1:0] jal_decode,
  input  logic [XLEN-1:0] jalr_decode,
  output logic            taken,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] raw_target_s;

  // Select the raw target and clear the two low address bits.
  always_comb begin
    taken = takes_redirect(pc_sel, br_true);
    case (pc_sel)
      PC_SEL_BR:   raw_target_s = br_decode;
      PC_SEL_JAL:  raw_target_s = jal_decode;
      PC_SEL_JALR: raw_target_s = jalr_decode;
      default:     raw_target_s = jal_decode;
    endcase
    target = raw_target_s & {{(XLEN-2){1'b1}}, 2'b00};
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: single-outstanding imem requests, a one-entry skid
// buffer for stalled responses, the IF/ID register and redirect/kill handling.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            stall_decode,
  input  logic [1:0]      pc_sel,
  input  logic            br_true,
  input  logic [XLEN-1:0] br_decode,
  input  logic [XLEN-1:0] jal_decode,
  input  logic [XLEN-1:0] jalr_decode,
  output logic [XLEN-1:0] pc_decode,
  output logic [31:0]     instr_decode,
  output logic            valid_decode
);

  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  logic [1:0]      state_r, state_nxt_s;
  logic [XLEN-1:0] fetch_pc_r, fetch_pc_nxt_s;
  logic [XLEN-1:0] req_pc_r, req_pc_nxt_s;
  logic            kill_r, kill_nxt_s;
  logic            req_valid_r;
  logic [XLEN-1:0] skid_pc_r, skid_pc_nxt_s;
  logic [31:0]     skid_instr_r, skid_instr_nxt_s;
  logic [XLEN-1:0] pc_decode_r, pc_decode_nxt_s;
  logic [31:0]     instr_decode_r, instr_decode_nxt_s;
  logic            valid_decode_r, valid_decode_nxt_s;

  logic            taken_s;
  logic [XLEN-1:0] target_s;
  logic            redirect_s;
  logic            deliver_s;
  logic [XLEN-1:0] deliver_pc_s;
  logic [31:0]     deliver_instr_s;

  fetch_stage_pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
    .pc_sel      (pc_sel),
    .br_true     (br_true),
    .br_decode   (br_decode),
    .jal_decode  (jal_decode),
    .jalr_decode (jalr_decode),
    .taken       (taken_s),
    .target      (target_s)
  );

  // Only an instruction actually leaving IF/ID this cycle may redirect fetch.
  assign redirect_s = valid_decode_r & ~stall_decode & taken_s;

  // Fetch FSM, skid capture and redirect/kill next-state logic.
  always_comb begin
    state_nxt_s      = state_r;
    fetch_pc_nxt_s   = fetch_pc_r;
    req_pc_nxt_s     = req_pc_r;
    kill_nxt_s       = kill_r;
    skid_pc_nxt_s    = skid_pc_r;
    skid_instr_nxt_s = skid_instr_r;
    deliver_s        = 1'b0;
    deliver_pc_s     = req_pc_r;
    deliver_instr_s  = imem_rsp_data;

    case (state_r)
      S_REQ: begin
        if (req_valid_r && imem_req_ready) begin
          req_pc_nxt_s   = fetch_pc_r;
          fetch_pc_nxt_s = fetch_pc_r + PC_STEP;
          state_nxt_s    = S_WAIT;
          if (redirect_s) begin
            kill_nxt_s = 1'b1;
          end else begin
            kill_nxt_s = kill_r;
          end
        end else begin
          state_nxt_s = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt_s = S_REQ;
          if (kill_r || redirect_s) begin
            kill_nxt_s = 1'b0;
          end else if (!stall_decode) begin
            deliver_s = 1'b1;
          end else begin
            skid_pc_nxt_s    = req_pc_r;
            skid_instr_nxt_s = imem_rsp_data;
            state_nxt_s      = S_HOLD;
          end
        end else if (redirect_s) begin
          kill_nxt_s = 1'b1;
        end else begin
          state_nxt_s = S_WAIT;
        end
      end
      S_HOLD: begin
        if (!stall_decode) begin
          state_nxt_s     = S_REQ;
          deliver_s       = ~redirect_s;
          deliver_pc_s    = skid_pc_r;
          deliver_instr_s = skid_instr_r;
        end else begin
          state_nxt_s = S_HOLD;
        end
      end
      default: begin
        state_nxt_s = S_REQ;
        kill_nxt_s  = 1'b0;
      end
    endcase

    if (redirect_s) begin
      fetch_pc_nxt_s = target_s;
    end else begin
      fetch_pc_nxt_s = fetch_pc_nxt_s;
    end
  end

  // IF/ID next value: redirect bubbles, stall holds, otherwise load or bubble.
  always_comb begin
    pc_decode_nxt_s    = pc_decode_r;
    instr_decode_nxt_s = instr_decode_r;
    valid_decode_nxt_s = valid_decode_r;
    if (redirect_s) begin
      instr_decode_nxt_s = INSTR_NOP;
      valid_decode_nxt_s = 1'b0;
    end else if (stall_decode) begin
      valid_decode_nxt_s = valid_decode_r;
    end else if (deliver_s) begin
      pc_decode_nxt_s    = deliver_pc_s;
      instr_decode_nxt_s = deliver_instr_s;
      valid_decode_nxt_s = 1'b1;
    end else begin
      instr_decode_nxt_s = INSTR_NOP;
      valid_decode_nxt_s = 1'b0;
    end
  end

  // State, skid and IF/ID registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= S_REQ;
      fetch_pc_r     <= RESET_PC;
      req_pc_r       <= {XLEN{1'b0}};
      kill_r         <= 1'b0;
      req_valid_r    <= 1'b0;
      skid_pc_r      <= {XLEN{1'b0}};
      skid_instr_r   <= INSTR_NOP;
      pc_decode_r    <= {XLEN{1'b0}};
      instr_decode_r <= INSTR_NOP;
      valid_decode_r <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      fetch_pc_r     <= fetch_pc_nxt_s;
      req_pc_r       <= req_pc_nxt_s;
      kill_r         <= kill_nxt_s;
      req_valid_r    <= (state_nxt_s == S_REQ);
      skid_pc_r      <= skid_pc_nxt_s;
      skid_instr_r   <= skid_instr_nxt_s;
      pc_decode_r    <= pc_decode_nxt_s;
      instr_decode_r <= instr_decode_nxt_s;
      valid_decode_r <= valid_decode_nxt_s;
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_addr      = fetch_pc_r;
  assign pc_decode      = pc_decode_r;
  assign instr_decode   = instr_decode_r;
  assign valid_decode   = valid_decode_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: randomized imem/decode environment, scoreboard of the
// architecturally expected instruction stream checked by a separate monitor.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall_decode;
  logic [1:0]  pc_sel;
  logic        br_true;
  logic [31:0] br_decode;
  logic [31:0] jal_decode;
  logic [31:0] jalr_decode;
  logic [31:0] pc_decode;
  logic [31:0] instr_decode;
  logic        valid_decode;

  fetch_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall_decode   (stall_decode),
    .pc_sel         (pc_sel),
    .br_true        (br_true),
    .br_decode      (br_decode),
    .jal_decode     (jal_decode),
    .jalr_decode    (jalr_decode),
    .pc_decode      (pc_decode),
    .instr_decode   (instr_decode),
    .valid_decode   (valid_decode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int deliveries = 0;
  int rdy_pct = 100;
  int lat_max = 1;
  logic [31:0] exp_q[$];
  logic [31:0] last_pushed;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F01;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_valid"}, {31'd0, valid_decode}, 32'd0);
    check({tag, "_instr"}, instr_decode, INSTR_NOP);
    check({tag, "_pc"}, pc_decode, 32'd0);
    check({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
  endtask

  // Instruction memory model: random ready, random response latency.
  initial begin
    logic        outstanding = 1'b0;
    int          lat_cnt = 0;
    logic [31:0] out_addr = 32'd0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        outstanding = 1'b0;
      end else begin
        if (imem_rsp_valid) outstanding = 1'b0;
        if (imem_req_valid && imem_req_ready) begin
          check("single_outstanding", {31'd0, outstanding}, 32'd0);
          check("addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
          outstanding = 1'b1;
          lat_cnt     = $urandom_range(1, lat_max);
          out_addr    = imem_addr;
        end
      end
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom();
      if (rst_n && outstanding && lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(out_addr);
        end
      end
      imem_req_ready = ($urandom_range(1, 100) <= rdy_pct);
    end
  end

  // Monitor: every fresh IF/ID load is popped from the scoreboard and compared.
  initial begin
    logic        rst_at_edge;
    logic        stall_at_edge;
    logic        shown_valid = 1'b0;
    logic [31:0] shown_pc = 32'd0;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      rst_at_edge   = rst_n;
      stall_at_edge = stall_decode;
      @(negedge clk);
      if (!rst_at_edge || !rst_n) begin
        shown_valid = 1'b0;
      end else if (stall_at_edge) begin
        check("stall_hold_valid", {31'd0, valid_decode}, {31'd0, shown_valid});
        if (shown_valid) check("stall_hold_pc", pc_decode, shown_pc);
      end else if (valid_decode) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_delivery: got pc %h expected no instruction", pc_decode);
        end else begin
          e = exp_q.pop_front();
          check("ifid_pc", pc_decode, e);
          check("ifid_instr", instr_decode, mem_word(e));
          shown_valid = 1'b1;
          shown_pc    = e;
          deliveries++;
        end
      end else begin
        check("bubble_nop", instr_decode, INSTR_NOP);
        shown_valid = 1'b0;
      end
    end
  end

  // One decode cycle; when decode consumes, push the next architectural PC.
  task automatic cycle(input logic stall, input logic [1:0] sel, input logic brt,
                       input logic [31:0] tgt);
    logic [31:0] nxt;
    stall_decode = stall;
    pc_sel       = sel;
    br_true      = brt;
    br_decode    = (sel == PC_SEL_BR)   ? tgt : $urandom();
    jal_decode   = (sel == PC_SEL_JAL)  ? tgt : $urandom();
    jalr_decode  = (sel == PC_SEL_JALR) ? tgt : $urandom();
    if (valid_decode && !stall) begin
      if (sel == PC_SEL_JAL || sel == PC_SEL_JALR || (sel == PC_SEL_BR && brt))
        nxt = {tgt[31:2], 2'b00};
      else
        nxt = last_pushed + 32'd4;
      exp_q.push_back(nxt);
      last_pushed = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!valid_decode && n < 40) begin
      cycle(1'b0, PC_SEL_SEQ, 1'b0, 32'd0);
      n++;
    end
    checks++;
    if (!valid_decode) begin
      errors++;
      $display("FAIL wait_%s: got no valid instruction, expected one within 40 cycles", tag);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    last_pushed = RESET_PC;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst_n        = 1'b0;
    stall_decode = 1'b0;
    pc_sel       = PC_SEL_SEQ;
    br_true      = 1'b0;
    br_decode    = 32'd0;
    jal_decode   = 32'd0;
    jalr_decode  = 32'd0;
    last_pushed  = RESET_PC;
    #22;
    reset_values("reset");
    release_reset();

    // Directed: sequential, JAL, stall into skid, branch not/taken, JALR.
    wait_valid("pc0");
    cycle(1'b0, PC_SEL_SEQ, 1'b0, 32'd0);
    wait_valid("pc4");
    cycle(1'b0, PC_SEL_JAL, 1'b0, 32'h0000_0100);
    wait_valid("jal");
    cycle(1'b0, PC_SEL_SEQ, 1'b0, 32'd0);
    wait_valid("seq");
    for (int i = 0; i < 3; i++) cycle(1'b1, PC_SEL_SEQ, 1'b0, 32'd0);
    cycle(1'b0, PC_SEL_SEQ, 1'b0, 32'd0);
    wait_valid("skid");
    cycle(1'b0, PC_SEL_BR, 1'b0, 32'h0000_0042);
    wait_valid("br_nt");
    cycle(1'b0, PC_SEL_BR, 1'b1, 32'h0000_0042);
    wait_valid("br_t");
    cycle(1'b0, PC_SEL_JALR, 1'b0, 32'h0000_0203);
    wait_valid("jalr");

    // Random: imem backpressure, variable latency, stalls and redirects.
    rdy_pct = 70;
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] sel;
      sel = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : PC_SEL_SEQ;
      cycle(($urandom_range(0, 3) == 0), sel, 1'($urandom_range(0, 1)), $urandom());
    end

    // Asynchronous reset while a request is outstanding.
    n = 0;
    while ((imem_req_valid || !rst_n) && n < 20) begin
      cycle(1'b0, PC_SEL_SEQ, 1'b0, 32'd0);
      n++;
    end
    #3;
    rst_n = 1'b0;
    #1;
    reset_values("async_reset");
    @(posedge clk);
    rdy_pct = 100;
    lat_max = 1;
    release_reset();
    n = 0;
    while (!imem_req_valid && n < 5) begin
      cycle(1'b0, PC_SEL_SEQ, 1'b0, 32'd0);
      n++;
    end
    check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_addr, RESET_PC);

    // PC wrap from the top of the address space back to zero.
    wait_valid("post_reset");
    cycle(1'b0, PC_SEL_JAL, 1'b0, 32'hFFFF_FFFF);
    wait_valid("top");
    cycle(1'b0, PC_SEL_SEQ, 1'b0, 32'd0);
    wait_valid("wrap");
    cycle(1'b0, PC_SEL_SEQ, 1'b0, 32'd0);
    wait_valid("final");
    #5;
    check("queue_drained", exp_q.size(), 32'd0);
    check("liveness", {31'd0, (deliveries >= 200)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
